ram_fifo_ctrl: RTL
==================

Name: ram_fifo_ctrl

Overview:
- Sequencing controller that sits directly upstream of the 4x8 RAM and drives its r_w, addrs and data_in ports.
- Converts independent producer push requests and consumer pop requests into single-port RAM accesses, so the RAM behaves as a 4-entry circular FIFO.
- Tracks the read pointer, write pointer and occupancy.
- Captures RAM read data and presents it with a one-cycle valid pulse.

Parameters:
DW, 8, data width; must match the RAM word width.
AW, 2, address width; FIFO depth is 2**AW = 4.

Ports:
clk  input  1  system clock, posedge active
rst  input  1  asynchronous, active-high reset; the same net also resets the RAM
wr_req  input  1  producer push request, level
wr_data  input  DW  push data, sampled when wr_ack is asserted
wr_ack  output  1  one-cycle pulse: push accepted
rd_req  input  1  consumer pop request, level
rd_data  output  DW  popped word, held until the next pop
rd_valid  output  1  one-cycle pulse: rd_data updated
full  output  1  count == 4
empty  output  1  count == 0
count  output  AW+1  occupancy, 0..4
ram_r_w  output  1  to RAM r_w (1 = write)
ram_addrs  output  AW  to RAM addrs
ram_data_in  output  DW  to RAM data_in
ram_data_out  input  DW  from RAM data_out

Behaviour:
- One clock and one reset. The reset is asynchronous and active-high.
- All outputs are driven from registers; there are no combinational paths from inputs to outputs.
- Reset values: state=IDLE, wptr=0, rptr=0, count=0, empty=1, full=0, wr_ack=0, rd_valid=0, rd_data=0, ram_r_w=0, ram_addrs=0, ram_data_in=0.
- State machine states: IDLE, WR, RD.
- IDLE, pop path: if rd_req && !empty, then rd_valid's pending op is started → RD. Set ram_r_w=0 and ram_addrs=rptr.
- IDLE, push path: else if wr_req && !full, then wr_ack=1 for one cycle → WR. Latch wr_data into ram_data_in, set ram_r_w=1 and ram_addrs=wptr.
- IDLE, otherwise: stay in IDLE with ram_r_w=0.
- Simultaneous push and pop in IDLE: the pop wins. The push waits; wr_req must stay high until wr_ack.
- WR (1 cycle):
  - The RAM writes at the posedge that ends WR.
  - At that edge: wptr += 1 (mod 4), count += 1, ram_r_w → 0, state → IDLE.
- RD (1 cycle):
  - The RAM drives ram_data_out on the negedge inside RD.
  - At the posedge ending RD: rd_data ← ram_data_out, rd_valid=1 for the next cycle, rptr += 1 (mod 4), count -= 1, state → IDLE.
- Latency and throughput:
  - Push: wr_ack follows the wr_req sample by 1 cycle; the data is in the RAM 2 edges after the request is sampled.
  - Pop: rd_valid is asserted 2 cycles after rd_req is sampled in IDLE.
  - Maximum throughput is one operation per 2 cycles.
- Pointers wrap 3 → 0 naturally at AW bits.
- full and empty are derived from count (the registered value), not from pointer equality.
- Push while full: ignored. No wr_ack, no state change, no RAM write.
- Pop while empty: ignored. No rd_valid, and rd_data is held.
- Held requests: a request held high across ops is re-accepted each time IDLE is re-entered, subject to the full/empty limits above.
- Reset mid-operation (WR or RD): the state machine aborts to IDLE, pointers and count clear, and pending pulses are dropped. RAM contents are cleared by the shared rst.

Test Plan:
1. Reset, then push 0xAA → wr_ack pulses once; 2 cycles later count=1 and empty=0; RAM address 0 holds 0xAA.
2. Push 0x11, 0x22, 0x33, 0x44 → full=1 and count=4. A 5th push of 0x55 gets no wr_ack, count stays 4, and no RAM write occurs.
3. Pop ×4 from full → rd_data = 0x11, 0x22, 0x33, 0x44, each with a one-cycle rd_valid. Then empty=1, and a 5th pop gives no rd_valid with rd_data held at 0x44.
4. Wrap-around: push 6 and pop 6 interleaved (values 0x01..0x06) → output order 0x01..0x06; ram_addrs sequence 0, 1, 2, 3, 0, 1 on writes.
5. With count=2, raise wr_req and rd_req together → RD is taken first (rd_valid, count=1), then WR (wr_ack, count=2).
6. Assert rst during a WR cycle → all outputs return to reset values immediately; a subsequent pop gets no rd_valid because empty=1.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// Sequencing controller that turns push/pop requests into single-port RAM accesses,
// making a 2**AW-word RAM behave as a circular FIFO with registered status and read data.
module ram_fifo_ctrl #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_req,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  input  logic          rd_req,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ram_r_w,
  output logic [AW-1:0] ram_addrs,
  output logic [DW-1:0] ram_data_in,
  input  logic [DW-1:0] ram_data_out
);

  localparam logic [AW:0] CNT_FULL = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wptr, wptr_nxt, rptr, rptr_nxt;
  logic [AW:0]   count_nxt;
  logic          wr_ack_nxt, rd_valid_nxt, ram_r_w_nxt;
  logic [AW-1:0] ram_addrs_nxt;
  logic [DW-1:0] ram_data_in_nxt, rd_data_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Pop has priority over push; a losing push simply waits for the next IDLE.
  always_comb begin
    state_nxt       = state;
    wptr_nxt        = wptr;
    rptr_nxt        = rptr;
    count_nxt       = count;
    wr_ack_nxt      = 1'b0;
    rd_valid_nxt    = 1'b0;
    ram_r_w_nxt     = ram_r_w;
    ram_addrs_nxt   = ram_addrs;
    ram_data_in_nxt = ram_data_in;
    rd_data_nxt     = rd_data;
    case (state)
      IDLE: begin
        if (rd_req && !empty) begin
          state_nxt     = RD;
          ram_r_w_nxt   = 1'b0;
          ram_addrs_nxt = rptr;
        end else if (wr_req && !full) begin
          state_nxt       = WR;
          wr_ack_nxt      = 1'b1;
          ram_data_in_nxt = wr_data;
          ram_r_w_nxt     = 1'b1;
          ram_addrs_nxt   = wptr;
        end else begin
          ram_r_w_nxt = 1'b0;
        end
      end
      WR: begin
        wptr_nxt    = wptr + 1'b1;
        count_nxt   = count + 1'b1;
        ram_r_w_nxt = 1'b0;
        state_nxt   = IDLE;
      end
      RD: begin
        rd_data_nxt  = ram_data_out;
        rd_valid_nxt = 1'b1;
        rptr_nxt     = rptr + 1'b1;
        count_nxt    = count - 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags are registered from the next occupancy so they stay glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      wr_ack      <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      ram_r_w     <= 1'b0;
      ram_addrs   <= '0;
      ram_data_in <= '0;
    end else begin
      wptr        <= wptr_nxt;
      rptr        <= rptr_nxt;
      count       <= count_nxt;
      empty       <= (count_nxt == '0);
      full        <= (count_nxt == CNT_FULL);
      wr_ack      <= wr_ack_nxt;
      rd_valid    <= rd_valid_nxt;
      rd_data     <= rd_data_nxt;
      ram_r_w     <= ram_r_w_nxt;
      ram_addrs   <= ram_addrs_nxt;
      ram_data_in <= ram_data_in_nxt;
    end
  end

endmodule
